alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one combinational 16-bit signed ALU (opc 3b, carry-in C, flags zer/neg)
//  between N_REQ requesters. Round-robin arbitration, operand latching, one-cycle
//  ALU evaluation, result/flag capture and per-requester completion pulse.
//  Sits between client FSMs (datapath controllers) and the single ALU instance.
// PARAMETERS
//  N_REQ   2    number of requesters (2..8)
//  CNT_W   16   width of completed-operation counter (wraps)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          async active-low reset
//  req        in   N_REQ      request i; held high until gnt[i]
//  req_A      in   16[N_REQ]  signed operand A of requester i
//  req_B      in   16[N_REQ]  signed operand B of requester i
//  req_C      in   N_REQ      carry-in of requester i
//  req_opc    in   3[N_REQ]   opcode of requester i
//  gnt        out  N_REQ      one-hot, 1-cycle pulse: operands of i latched
//  done       out  N_REQ      one-hot, 1-cycle pulse: rsp_* valid for i
//  rsp_W      out  16         signed result (held until next done)
//  rsp_zer    out  1          zero flag of rsp_W
//  rsp_neg    out  1          sign flag of rsp_W
//  rsp_err    out  1          1 = opcode 3'b111 rejected
//  busy       out  1          high in EXEC and DONE
//  op_count   out  CNT_W      count of done pulses, wraps to 0
//  alu_A/alu_B out 16         to ALU A/B
//  alu_C      out  1          to ALU C
//  alu_opc    out  3          to ALU opc
//  alu_W      in   16         from ALU W
//  alu_zer/alu_neg in 1       from ALU flags
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; gnt=0, done=0, rsp_W=0, rsp_zer=0,
//   rsp_neg=0, rsp_err=0, busy=0, op_count=0, last-grant ptr=N_REQ-1
//   (requester 0 highest priority first). Reset mid-op aborts: no done.
//  FSM IDLE -> EXEC -> DONE -> IDLE; 3 cycles per op, latency gnt->done = 2.
//  IDLE: if |req, pick first set bit scanning from ptr+1 (mod N_REQ); latch
//   A,B,C,opc and index; gnt[i]=1 for that cycle; ptr<=i; go EXEC. Else stay.
//  EXEC: alu_* driven from latched regs (stable whole cycle); at clock edge
//   capture alu_W/zer/neg into rsp_*, rsp_err=0. If latched opc=3'b111: no
//   capture of ALU, rsp_W=0, rsp_zer=1, rsp_neg=0, rsp_err=1. go DONE.
//  DONE: done[idx]=1, op_count++ (wrap 2^CNT_W-1 -> 0); go IDLE.
//  alu_* outside EXEC: A=0,B=0,C=0,opc=3'b000 (no X on ALU inputs).
//  Requests ignored while busy; req dropped before gnt = no op. req held after
//   done = new request; round-robin gives other pending requester priority.
//  Simultaneous requests: exactly one gnt; loser served next IDLE cycle.
//  Arithmetic: no width extension; ALU wraps mod 2^16; flags taken from ALU.
// STRUCTURE
//  Package alu_pkg: opcode localparams (OP_ADDC=000, OP_2AB=001, OP_INC=010,
//   OP_SCALE=011, OP_AND=100, OP_OR=101, OP_NOT=110, OP_ILL=111), state enum
//   {S_IDLE,S_EXEC,S_DONE}, DATA_W=16.
//  Sub-module rr_arbiter #(N_REQ): req, ptr -> one-hot grant + index (comb).
// TESTING
//  Reset: rst_n=0 mid-EXEC -> all outputs 0, no done, next op from req0.
//  Single op: req[0], A=5,B=7,C=1,opc=000 -> gnt[0] c0, done[0] c2, rsp_W=13, zer=0,neg=0.
//  Contention: req=2'b11 held -> gnt order 0,1,0,1; each done 3 cycles apart.
//  Flags: opc=110,B=16'hFFFF -> rsp_W=0,zer=1; opc=000,A=-3,B=1,C=0 -> W=-2,neg=1.
//  Illegal: opc=111 -> rsp_err=1, rsp_W=0, zer=1; next legal op clears rsp_err.
//  Counter: 2^CNT_W ops (CNT_W=4 build) -> op_count wraps 15 -> 0.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode, width and state definitions for the ALU-sharing controller.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADDC  = 3'b000;
  localparam logic [2:0] OP_2AB   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_SCALE = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_NOT   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the shared ALU: per-requester operands in, pulses/results out.
// Wires only, no latency.
// req is held until gnt; ctrl ignores req while busy.
interface alu_share_ctrl_if
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][DATA_W-1:0] req_A;
  logic [N_REQ-1:0][DATA_W-1:0] req_B;
  logic [N_REQ-1:0]             req_C;
  logic [N_REQ-1:0][2:0]        req_opc;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0]             done;
  logic [DATA_W-1:0]            rsp_W;
  logic                         rsp_zer;
  logic                         rsp_neg;
  logic                         rsp_err;
  logic                         busy;
  logic [CNT_W-1:0]             op_count;

  modport ctrl (
    input  req, req_A, req_B, req_C, req_opc,
    output gnt, done, rsp_W, rsp_zer, rsp_neg, rsp_err, busy, op_count
  );

  modport client (
    output req, req_A, req_B, req_C, req_opc,
    input  gnt, done, rsp_W, rsp_zer, rsp_neg, rsp_err, busy, op_count
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin pick: first set request scanning upward from ptr+1, wrapping.
// Purely combinational, zero latency.
// No backpressure; caller decides when the grant is taken.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan candidates ptr+1 .. ptr+N_REQ (mod N_REQ); the last grantee comes last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU among N_REQ requesters, round-robin.
// 3 cycles per op: gnt in IDLE, ALU evaluated in EXEC, done pulse in DONE.
// Requests are ignored while busy; losers are served on the next IDLE cycle.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.ctrl    bus,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic              alu_C,
  output logic [2:0]        alu_opc,
  input  logic [DATA_W-1:0] alu_W,
  input  logic              alu_zer,
  input  logic              alu_neg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   lat_idx;
  logic [DATA_W-1:0]  lat_A;
  logic [DATA_W-1:0]  lat_B;
  logic               lat_C;
  logic [2:0]         lat_opc;
  logic [DATA_W-1:0]  rsp_W;
  logic               rsp_zer;
  logic               rsp_neg;
  logic               rsp_err;
  logic [CNT_W-1:0]   op_count;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Sequencer: latch the winner's operands, capture the ALU result, count completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= IDX_W'(N_REQ - 1);
      lat_idx  <= '0;
      lat_A    <= '0;
      lat_B    <= '0;
      lat_C    <= 1'b0;
      lat_opc  <= OP_ADDC;
      rsp_W    <= '0;
      rsp_zer  <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            lat_A   <= bus.req_A[arb_idx];
            lat_B   <= bus.req_B[arb_idx];
            lat_C   <= bus.req_C[arb_idx];
            lat_opc <= bus.req_opc[arb_idx];
            lat_idx <= arb_idx;
            ptr     <= arb_idx;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (lat_opc == OP_ILL) begin
            // Illegal opcode: report a zero result flagged as an error.
            rsp_W   <= '0;
            rsp_zer <= 1'b1;
            rsp_neg <= 1'b0;
            rsp_err <= 1'b1;
          end else begin
            rsp_W   <= alu_W;
            rsp_zer <= alu_zer;
            rsp_neg <= alu_neg;
            rsp_err <= 1'b0;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          op_count <= op_count + 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Grant is the arbiter's choice in IDLE, forced low while reset is asserted.
  always_comb begin
    bus.gnt = '0;
    if (rst_n && state == S_IDLE) bus.gnt = arb_gnt;
  end

  // Completion pulse goes to the requester whose operands were latched.
  always_comb begin
    bus.done = '0;
    if (state == S_DONE) bus.done[lat_idx] = 1'b1;
  end

  // ALU inputs carry latched operands only in EXEC; quiet zeros otherwise.
  always_comb begin
    alu_A   = '0;
    alu_B   = '0;
    alu_C   = 1'b0;
    alu_opc = OP_ADDC;
    if (state == S_EXEC) begin
      alu_A   = lat_A;
      alu_B   = lat_B;
      alu_C   = lat_C;
      alu_opc = lat_opc;
    end
  end

  assign bus.rsp_W    = rsp_W;
  assign bus.rsp_zer  = rsp_zer;
  assign bus.rsp_neg  = rsp_neg;
  assign bus.rsp_err  = rsp_err;
  assign bus.busy     = (state != S_IDLE);
  assign bus.op_count = op_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the alu_* port.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_share_ctrl;

  localparam int N_REQ = 2;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_A, alu_B, alu_W;
  logic        alu_C, alu_zer, alu_neg;
  logic [2:0]  alu_opc;

  int checks = 0;
  int failures = 0;

  alu_share_ctrl_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  alu_share_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_A   (alu_A),
    .alu_B   (alu_B),
    .alu_C   (alu_C),
    .alu_opc (alu_opc),
    .alu_W   (alu_W),
    .alu_zer (alu_zer),
    .alu_neg (alu_neg)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU (16-bit wrap, flags from result).
  always_comb begin
    case (alu_opc)
      3'b000:  alu_W = alu_A + alu_B + {15'd0, alu_C};
      3'b001:  alu_W = (alu_A << 1) + alu_B;
      3'b010:  alu_W = alu_A + 16'd1;
      3'b011:  alu_W = alu_A << 2;
      3'b100:  alu_W = alu_A & alu_B;
      3'b101:  alu_W = alu_A | alu_B;
      3'b110:  alu_W = ~alu_B;
      default: alu_W = 16'h0000;
    endcase
    alu_zer = (alu_W == 16'h0000);
    alu_neg = alu_W[15];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete op from requester i alone; checks gnt, EXEC drive and result.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [2:0] op, input logic [15:0] exp_w,
                       input logic exp_z, input logic exp_n, input logic exp_e,
                       input string tag);
    logic [1:0] oh;
    oh = 2'(1 << i);
    bus.req_A[i]   = a;
    bus.req_B[i]   = b;
    bus.req_C[i]   = c;
    bus.req_opc[i] = op;
    bus.req[i]     = 1'b1;
    #1;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
    tick();
    bus.req[i] = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".gnt_exec"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".alu_A"}, 32'(alu_A), 32'(a));
    chk({tag, ".alu_opc"}, 32'(alu_opc), 32'(op));
    tick();
    chk({tag, ".done"}, 32'(bus.done), 32'(oh));
    chk({tag, ".W"}, 32'(bus.rsp_W), 32'(exp_w));
    chk({tag, ".zer"}, 32'(bus.rsp_zer), 32'(exp_z));
    chk({tag, ".neg"}, 32'(bus.rsp_neg), 32'(exp_n));
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_e));
    tick();
    chk({tag, ".done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_oh;
    bus.req     = '0;
    bus.req_A   = '0;
    bus.req_B   = '0;
    bus.req_C   = '0;
    bus.req_opc = '0;

    // Reset values
    #12;
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.W", 32'(bus.rsp_W), 32'd0);
    chk("rst.zer", 32'(bus.rsp_zer), 32'd0);
    chk("rst.err", 32'(bus.rsp_err), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.cnt", 32'(bus.op_count), 32'd0);
    chk("rst.alu_A", 32'(alu_A), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single op: 5 + 7 + 1 = 13
    do_op(0, 16'd5, 16'd7, 1'b1, 3'b000, 16'd13, 1'b0, 1'b0, 1'b0, "single");
    chk("single.cnt", 32'(bus.op_count), 32'd1);

    // Flags: ~FFFF = 0 (zero); -3 + 1 = -2 (negative)
    do_op(0, 16'd0, 16'hFFFF, 1'b0, 3'b110, 16'h0000, 1'b1, 1'b0, 1'b0, "not_zero");
    do_op(0, 16'hFFFD, 16'd1, 1'b0, 3'b000, 16'hFFFE, 1'b0, 1'b1, 1'b0, "neg");

    // Illegal opcode, then a legal op clears the error: 2 & 3 = 2
    do_op(0, 16'd1, 16'd2, 1'b0, 3'b111, 16'h0000, 1'b1, 1'b0, 1'b1, "illegal");
    do_op(0, 16'd2, 16'd3, 1'b0, 3'b100, 16'h0002, 1'b0, 1'b0, 1'b0, "after_ill");
    chk("after_ill.cnt", 32'(bus.op_count), 32'd5);

    // Reset mid-EXEC on a requester-1 op: everything clears, no done
    bus.req_A[1]   = 16'd100;
    bus.req_B[1]   = 16'd1;
    bus.req_opc[1] = 3'b000;
    bus.req[1]     = 1'b1;
    #1;
    chk("midrst.gnt", 32'(bus.gnt), 32'b10);
    tick();
    bus.req[1] = 1'b0;
    chk("midrst.busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.cnt", 32'(bus.op_count), 32'd0);
    chk("midrst.W", 32'(bus.rsp_W), 32'd0);
    chk("midrst.alu_A", 32'(alu_A), 32'd0);
    tick();
    chk("midrst.done2", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Contention, both held: 0,1,0,1. req0: 10+1 = 11; req1: 20|3 = 23
    bus.req_A   = {16'd20, 16'd10};
    bus.req_B   = {16'd3, 16'd1};
    bus.req_C   = 2'b00;
    bus.req_opc = {3'b101, 3'b000};
    bus.req     = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("cont.gnt", 32'(bus.gnt), 32'(exp_oh));
      tick();
      chk("cont.gnt_busy", 32'(bus.gnt), 32'd0);
      tick();
      chk("cont.done", 32'(bus.done), 32'(exp_oh));
      chk("cont.W", 32'(bus.rsp_W), (n % 2 == 0) ? 32'd11 : 32'd23);
      tick();
      chk("cont.done_clr", 32'(bus.done), 32'd0);
    end
    bus.req = 2'b00;
    chk("cont.cnt", 32'(bus.op_count), 32'd4);

    // Counter wrap at 2^4 ops
    for (int n = 0; n < 11; n++)
      do_op(0, 16'd1, 16'd1, 1'b0, 3'b010, 16'd2, 1'b0, 1'b0, 1'b0, "wrap_op");
    chk("wrap.cnt15", 32'(bus.op_count), 32'd15);
    do_op(0, 16'd1, 16'd1, 1'b0, 3'b010, 16'd2, 1'b0, 1'b0, 1'b0, "wrap_last");
    chk("wrap.cnt0", 32'(bus.op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
